// File: rtl/alarm_pkg.sv
// Shared types and default parameters for the alarm manager slice.
package alarm_pkg;

  localparam int BLINK_HALF_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ALERT    = 2'd2,
    ST_CLEARING = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/alarm_manager_if.sv
// Signal bundle between the alarm controller and its environment.
interface alarm_manager_if #(
  parameter int CNT_W = alarm_pkg::CNT_W_DEF
) ();
  import alarm_pkg::*;

  // No valid/ready handshake: every input is a level sampled on each rising clk edge,
  // and every output is decoded from registers only.
  logic              alarm;
  logic              arm;
  logic              ack;
  logic              clr_cnt;
  logic              armed;
  logic              alert;
  logic              siren;
  logic [CNT_W-1:0]  event_count;
  alarm_state_e      state;

  modport master (
    output alarm, arm, ack, clr_cnt,
    input  armed, alert, siren, event_count, state
  );

  modport slave (
    input  alarm, arm, ack, clr_cnt,
    output armed, alert, siren, event_count, state
  );

endinterface

// File: rtl/alarm_manager_blink_gen.sv
// Siren blink pattern: on for BLINK_HALF cycles, off for BLINK_HALF, restarting "on" whenever en drops.
module blink_gen #(
  parameter int BLINK_HALF = alarm_pkg::BLINK_HALF_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic out
);

  localparam logic [7:0] LAST = 8'(BLINK_HALF - 1);

  logic [7:0] cnt_q;
  logic       phase_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b1;
    end else if (!en) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_q   <= 8'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  // Gating with en makes the siren fall the moment the controller leaves ALERT.
  assign out = en & phase_q;

endmodule

// File: rtl/alarm_manager.sv
// Alarm controller: arm/alert/clear FSM, alarm rise detector and saturating alert-entry counter.
module alarm_manager
  import alarm_pkg::*;
#(
  parameter int BLINK_HALF = BLINK_HALF_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  alarm_manager_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alarm_state_e     state_q, state_d;
  logic             alarm_q;
  logic             rise;
  logic             enter_alert;
  logic [CNT_W-1:0] count_q;
  logic             blink_out;

  assign rise = bus.alarm & ~alarm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_DISARMED;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm_q <= bus.alarm;
    end
  end

  // Losing arm wins over everything else in any armed state.
  always_comb begin
    state_d     = state_q;
    enter_alert = 1'b0;
    case (state_q)
      ST_DISARMED: if (bus.arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!bus.arm) state_d = ST_DISARMED;
        else if (rise) begin
          state_d     = ST_ALERT;
          enter_alert = 1'b1;
        end
      end
      ST_ALERT: begin
        if (!bus.arm)     state_d = ST_DISARMED;
        else if (bus.ack) state_d = bus.alarm ? ST_CLEARING : ST_ARMED;
      end
      ST_CLEARING: begin
        if (!bus.arm)        state_d = ST_DISARMED;
        else if (!bus.alarm) state_d = ST_ARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (bus.clr_cnt) begin
      count_q <= enter_alert ? CNT_W'(1) : '0;
    end else if (enter_alert && count_q != CNT_MAX) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_ALERT),
    .out   (blink_out)
  );

  assign bus.armed       = (state_q != ST_DISARMED);
  assign bus.alert       = (state_q == ST_ALERT);
  assign bus.siren       = blink_out;
  assign bus.event_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_alarm_manager.sv
// Directed and randomized checks of alarm_manager against a mode/age reference model.
module tb_alarm_manager;
  import alarm_pkg::*;

  localparam int BH   = 4;
  localparam int CW   = 2;
  localparam int W    = 2 + 3 + CW;
  localparam int MAXC = (1 << CW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_manager_if #(.CNT_W(CW)) bus ();

  alarm_manager #(.BLINK_HALF(BH), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // reference model: mode 0=disarmed 1=armed 2=alert 3=clearing, age = cycles spent in alert
  int   m_mode, m_count, m_age;
  logic m_prev;

  function automatic alarm_state_e mode_to_state(input int mode);
    case (mode)
      1:       return ST_ARMED;
      2:       return ST_ALERT;
      3:       return ST_CLEARING;
      default: return ST_DISARMED;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_age = 0; m_prev = 1'b0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  rise, entering;
    rise     = bus.alarm && !m_prev;
    nxt      = m_mode;
    entering = 0;
    if (m_mode == 0) begin
      if (bus.arm) nxt = 1;
    end else if (!bus.arm) begin
      nxt = 0;
    end else if (m_mode == 1) begin
      if (rise) begin nxt = 2; entering = 1; end
    end else if (m_mode == 2) begin
      if (bus.ack) nxt = bus.alarm ? 3 : 1;
    end else begin
      if (!bus.alarm) nxt = 1;
    end
    if (bus.clr_cnt)  m_count = entering ? 1 : 0;
    else if (entering) m_count = (m_count + 1 > MAXC) ? MAXC : m_count + 1;
    m_age  = (nxt == 2 && m_mode == 2) ? m_age + 1 : 0;
    m_mode = nxt;
    m_prev = bus.alarm;
  endtask

  function automatic logic [W-1:0] model_expect();
    logic s;
    s = (m_mode == 2) && (((m_age / BH) % 2) == 0);
    return {mode_to_state(m_mode), 1'(m_mode != 0), 1'(m_mode == 2), s, CW'(m_count)};
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("state",       32'(bus.state),       32'(e[W-1:W-2]));
    chk("armed",       32'(bus.armed),       32'(e[CW+2]));
    chk("alert",       32'(bus.alert),       32'(e[CW+1]));
    chk("siren",       32'(bus.siren),       32'(e[CW]));
    chk("event_count", 32'(bus.event_count), 32'(e[CW-1:0]));
  endtask

  // drivers
  task automatic drive(input logic a, input logic ar, input logic ak, input logic cl);
    bus.alarm = a; bus.arm = ar; bus.ack = ak; bus.clr_cnt = cl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_expect());
    #1;
    check_outputs();
  endtask

  logic [19:0] pat;
  logic [19:0] seen;
  int          sat_exp[5];

  initial begin
    pat     = 20'b1111_0000_1111_0000_1111;
    sat_exp = '{1, 2, 3, 3, 3};

    // reset state, checked before any clock edge and across an edge while held
    reset = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    #2;
    exp_q.push_back(model_expect());
    check_outputs();
    @(posedge clk); #1;
    exp_q.push_back(model_expect());
    check_outputs();
    reset = 1'b0;

    // idle until arm is seen
    repeat (3) cycle();

    // arm, then rise: alert and siren one cycle after the rise is sampled
    drive(0, 1, 0, 0); cycle();
    chk("armed_after_arm", 32'(bus.armed), 1);
    drive(1, 1, 0, 0); cycle();
    chk("alert_latency", 32'(bus.alert), 1);
    chk("siren_latency", 32'(bus.siren), 1);
    chk("count_first",   32'(bus.event_count), 1);

    // blink pattern over 20 cycles of ALERT, alarm level irrelevant without ack
    seen[19] = bus.siren;
    for (int i = 1; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), 1, 0, 0);
      cycle();
      seen[19-i] = bus.siren;
      chk("alert_hold", 32'(bus.alert), 1);
    end
    chk("siren_pattern", 32'(seen), 32'(pat));

    // ack with alarm high -> CLEARING; held alarm does not re-alert
    drive(1, 1, 1, 0); cycle();
    chk("clearing_state", 32'(bus.state), 32'(ST_CLEARING));
    drive(1, 1, 0, 0);
    repeat (5) cycle();
    chk("no_realert", 32'(bus.alert), 0);
    drive(0, 1, 0, 0); cycle();
    chk("back_to_armed", 32'(bus.state), 32'(ST_ARMED));

    // saturation with 2-bit counter
    drive(0, 1, 0, 1); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0); cycle();
      drive(1, 1, 0, 0); cycle();
      chk("sat_count", 32'(bus.event_count), 32'(sat_exp[i]));
      drive(0, 1, 1, 0); cycle();
    end
    drive(1, 1, 0, 1); cycle();
    chk("clr_with_entry", 32'(bus.event_count), 1);

    // disarm wins over ack during ALERT
    drive(1, 0, 1, 0); cycle();
    chk("disarm_armed", 32'(bus.armed), 0);
    chk("disarm_count", 32'(bus.event_count), 1);

    // randomized traffic against the model
    drive(0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) bus.alarm = ~bus.alarm;
      bus.arm     = ($urandom_range(0, 15) != 0);
      bus.ack     = ($urandom_range(0, 4) == 0);
      bus.clr_cnt = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // asynchronous reset in the middle of ALERT
    drive(0, 1, 0, 0); cycle(); cycle();
    drive(1, 1, 0, 0); cycle();
    chk("pre_reset_alert", 32'(bus.alert), 1);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_expect());
    check_outputs();
    chk("reset_alert_drop", 32'(bus.alert), 0);
    chk("reset_siren_drop", 32'(bus.siren), 0);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_manager.md
ALARM_MANAGER -- requirements
Module: alarm_manager

Interface
REQ-001 Parameter BLINK_HALF, default 4: siren half-period in clk cycles, legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of event_count.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alarm  input  1  level alarm from the upstream consecutive-ones detector, synchronous to clk.
REQ-006 arm  input  1  level; 1 = system armed, 0 = disarm request.
REQ-007 ack  input  1  operator acknowledge, sampled every cycle.
REQ-008 clr_cnt  input  1  synchronous clear of event_count.
REQ-009 armed  output  1  high in states ARMED, ALERT and CLEARING.
REQ-010 alert  output  1  high only in state ALERT.
REQ-011 siren  output  1  blinking siren drive, active only in ALERT.
REQ-012 event_count  output  CNT_W  number of alert entries, saturating.

Function
REQ-013 FSM states: DISARMED, ARMED, ALERT, CLEARING; all outputs decoded from registers only, no input-to-output combinational path.
REQ-014 alarm_q register holds the previous-cycle alarm; rise = alarm & ~alarm_q.
REQ-015 DISARMED: arm=1 -> ARMED next edge; otherwise stay.
REQ-016 In every state other than DISARMED, arm=0 -> DISARMED next edge, with priority over all other conditions.
REQ-017 ARMED: rise=1 -> ALERT next edge; alarm already high at arm time does not trigger (edge only).
REQ-018 ALERT: ack=1 with alarm=1 -> CLEARING; ack=1 with alarm=0 -> ARMED; ack=0 -> stay, regardless of alarm level.
REQ-019 CLEARING: alarm=0 -> ARMED next edge; otherwise stay; rises are ignored in this state.
REQ-020 Latency: rise sampled at edge N -> alert=1 and siren=1 in the cycle after edge N.
REQ-021 Siren pattern: 1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating; phase restarts at "on" on every ALERT entry.
REQ-022 siren=0 in every cycle the state is not ALERT; blink counter and phase are held at their restart values outside ALERT.
REQ-023 event_count increments by 1 on every ARMED->ALERT transition and saturates at 2^CNT_W-1 (no wrap).
REQ-024 clr_cnt=1 zeroes event_count; clr_cnt coinciding with an increment yields 1.
REQ-025 Disarming does not alter event_count.

Reset
REQ-026 reset=1 forces state=DISARMED, alarm_q=0, event_count=0, blink counter=0 and phase=on, asynchronously.
REQ-027 During and after reset until the next edge: armed=0, alert=0, siren=0.
REQ-028 Reset asserted mid-ALERT drops siren and alert immediately (asynchronously) and does not count an event.
REQ-029 After reset deassertion, the block is idle until arm=1 is sampled.

Structure
REQ-030 Shared package alarm_pkg holds the state enum type (2-bit encoding) and the default BLINK_HALF/CNT_W constants.
REQ-031 One sub-module blink_gen (ports: clk, reset, en, out; parameter BLINK_HALF) generates the siren pattern; restart is driven by en=0.
REQ-032 The FSM, edge detector and event counter reside in alarm_manager.

Verification
REQ-033 Reset, then arm=1 for 1 cycle, then alarm 0->1 -> armed=1 after 1 edge; alert=1 and siren=1 exactly 1 cycle after the rise is sampled; event_count=1.
REQ-034 In ALERT with BLINK_HALF=4 and no ack for 20 cycles -> siren sequence 1111 0000 1111 0000 1111; alert remains 1 throughout.
REQ-035 ack=1 while alarm=1 -> CLEARING, alert=0, siren=0; alarm held 1 for 5 cycles with a second rise attempt -> no re-alert; alarm=0 -> ARMED next edge.
REQ-036 CNT_W=2, 5 alert/ack cycles -> event_count reads 1,2,3,3,3; clr_cnt together with a 6th alert entry -> event_count=1.
REQ-037 arm=0 and ack=1 in the same cycle during ALERT -> DISARMED, armed=0; event_count unchanged.
REQ-038 reset pulsed mid-ALERT between clock edges -> alert and siren drop without a clock edge; state DISARMED; event_count=0.
